// File: rtl/gtfmac_vnc_lat_mon_core.sv
// Latency monitor capture core: pairs send/receive timestamps, stores them in a
// RAM-backed FIFO and keeps running delta statistics for the register block.
module gtfmac_vnc_lat_mon_core #(
    parameter int TIMER_WIDTH    = 16,
    parameter int RAM_DEPTH      = 4096,
    parameter int RAM_ADDR_WIDTH = 12
) (
    input  logic                      axi_aclk,
    input  logic                      axi_aresetn,
    input  logic                      lm_go,
    input  logic                      lm_clear,
    input  logic                      lm_pop,
    input  logic [31:0]               lm_lat_pkt_cnt,
    input  logic [TIMER_WIDTH-1:0]    timer,
    input  logic                      tx_sop,
    input  logic                      rx_sop,
    output logic                      lm_full,
    output logic [RAM_ADDR_WIDTH:0]   lm_datav,
    output logic [TIMER_WIDTH-1:0]    lm_snd_time,
    output logic [TIMER_WIDTH-1:0]    lm_rcv_time,
    output logic                      lm_time_rdy,
    output logic [31:0]               lm_delta_time_accu,
    output logic [31:0]               lm_delta_time_idx,
    output logic [TIMER_WIDTH-1:0]    lm_delta_time_max,
    output logic [TIMER_WIDTH-1:0]    lm_delta_time_min
);

    localparam int PW = RAM_ADDR_WIDTH + 1;
    localparam int DW = 2 * TIMER_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_WAIT_RX,
        S_WRITE,
        S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [TIMER_WIDTH-1:0] snd_q, snd_d;
    logic [TIMER_WIDTH-1:0] rcv_q, rcv_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [31:0]            pairs_q, pairs_d;
    logic [31:0]            accu_q, accu_d;
    logic [31:0]            idx_q, idx_d;
    logic [TIMER_WIDTH-1:0] max_q, max_d;
    logic [TIMER_WIDTH-1:0] min_q, min_d;
    logic                   pop_v_q, pop_v_d;
    logic                   pop_empty_q, pop_empty_d;
    logic [TIMER_WIDTH-1:0] snd_out_q, snd_out_d;
    logic [TIMER_WIDTH-1:0] rcv_out_q, rcv_out_d;
    logic                   rdy_q, rdy_d;
    logic [DW-1:0]          rd_data_q;

    logic [DW-1:0]          mem [RAM_DEPTH];

    logic [PW-1:0]          datav;
    logic                   full;
    logic                   has_data;
    logic                   pop_ok;
    logic                   rd_en;
    logic                   wr_en;
    logic [TIMER_WIDTH-1:0] delta;
    logic [31:0]            pairs_inc;

    assign datav     = wr_ptr_q - rd_ptr_q;
    assign full      = (datav == PW'(RAM_DEPTH));
    assign has_data  = (datav != '0);
    assign pop_ok    = lm_pop && !pop_v_q;
    assign rd_en     = pop_ok && has_data && !lm_clear;
    assign wr_en     = (state_q == S_WRITE) && !full;
    // Modular subtraction gives the right small delta across a timer wrap.
    assign delta     = rcv_q - snd_q;
    assign pairs_inc = pairs_q + 32'd1;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        snd_d   = snd_q;
        rcv_d   = rcv_q;
        if (lm_clear || !lm_go) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_ARMED;
                S_ARMED: begin
                    if (tx_sop) begin
                        snd_d   = timer;
                        state_d = S_WAIT_RX;
                    end
                end
                S_WAIT_RX: begin
                    if (rx_sop) begin
                        rcv_d   = timer;
                        state_d = S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (lm_lat_pkt_cnt != 32'd0 && pairs_inc == lm_lat_pkt_cnt)
                        state_d = S_DONE;
                    else
                        state_d = S_ARMED;
                end
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pairs_d     = pairs_q;
        accu_d      = accu_q;
        idx_d       = idx_q;
        max_d       = max_q;
        min_d       = min_q;
        pop_v_d     = pop_ok;
        pop_empty_d = !has_data;
        if (lm_clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            pairs_d     = '0;
            accu_d      = '0;
            idx_d       = '0;
            max_d       = '0;
            min_d       = '1;
            pop_empty_d = 1'b1;
        end else begin
            if (state_q == S_WRITE) begin
                if (!full)
                    wr_ptr_d = wr_ptr_q + PW'(1);
                pairs_d = pairs_inc;
                accu_d  = accu_q + 32'(delta);
                idx_d   = idx_q + 32'd1;
                if (delta > max_q) max_d = delta;
                if (delta < min_q) min_d = delta;
            end
            if (rd_en)
                rd_ptr_d = rd_ptr_q + PW'(1);
        end

        rdy_d     = pop_v_q;
        snd_out_d = snd_out_q;
        rcv_out_d = rcv_out_q;
        if (pop_v_q) begin
            // A clear landing on an in-flight pop still completes it, but with zero data.
            if (pop_empty_q || lm_clear) begin
                snd_out_d = '0;
                rcv_out_d = '0;
            end else begin
                snd_out_d = rd_data_q[TIMER_WIDTH-1:0];
                rcv_out_d = rd_data_q[DW-1:TIMER_WIDTH];
            end
        end
    end

    // NOTE: the FIFO storage is deliberately not reset; the pointers define which entries are valid.
    always_ff @(posedge axi_aclk) begin
        if (wr_en)
            mem[wr_ptr_q[RAM_ADDR_WIDTH-1:0]] <= {rcv_q, snd_q};
        if (rd_en)
            rd_data_q <= mem[rd_ptr_q[RAM_ADDR_WIDTH-1:0]];
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            state_q     <= S_IDLE;
            snd_q       <= '0;
            rcv_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pairs_q     <= '0;
            accu_q      <= '0;
            idx_q       <= '0;
            max_q       <= '0;
            min_q       <= '1;
            pop_v_q     <= 1'b0;
            pop_empty_q <= 1'b0;
            snd_out_q   <= '0;
            rcv_out_q   <= '0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            snd_q       <= snd_d;
            rcv_q       <= rcv_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pairs_q     <= pairs_d;
            accu_q      <= accu_d;
            idx_q       <= idx_d;
            max_q       <= max_d;
            min_q       <= min_d;
            pop_v_q     <= pop_v_d;
            pop_empty_q <= pop_empty_d;
            snd_out_q   <= snd_out_d;
            rcv_out_q   <= rcv_out_d;
            rdy_q       <= rdy_d;
        end
    end

    assign lm_full            = full;
    assign lm_datav           = datav;
    assign lm_snd_time        = snd_out_q;
    assign lm_rcv_time        = rcv_out_q;
    assign lm_time_rdy        = rdy_q;
    assign lm_delta_time_accu = accu_q;
    assign lm_delta_time_idx  = idx_q;
    assign lm_delta_time_max  = max_q;
    assign lm_delta_time_min  = min_q;

endmodule

// File: tb/tb_gtfmac_vnc_lat_mon_core.sv
// Directed self-checking bench for the latency monitor capture core.
module tb_gtfmac_vnc_lat_mon_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lm_go, lm_clear, lm_pop;
    logic [31:0] lm_lat_pkt_cnt;
    logic [15:0] timer;
    logic        tx_sop, rx_sop;
    logic        lm_full;
    logic [12:0] lm_datav;
    logic [15:0] lm_snd_time, lm_rcv_time;
    logic        lm_time_rdy;
    logic [31:0] lm_delta_time_accu, lm_delta_time_idx;
    logic [15:0] lm_delta_time_max, lm_delta_time_min;

    int n_checks = 0;
    int n_fail   = 0;

    gtfmac_vnc_lat_mon_core #(
        .TIMER_WIDTH(16), .RAM_DEPTH(4096), .RAM_ADDR_WIDTH(12)
    ) dut (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .lm_go(lm_go), .lm_clear(lm_clear), .lm_pop(lm_pop),
        .lm_lat_pkt_cnt(lm_lat_pkt_cnt), .timer(timer),
        .tx_sop(tx_sop), .rx_sop(rx_sop),
        .lm_full(lm_full), .lm_datav(lm_datav),
        .lm_snd_time(lm_snd_time), .lm_rcv_time(lm_rcv_time),
        .lm_time_rdy(lm_time_rdy),
        .lm_delta_time_accu(lm_delta_time_accu), .lm_delta_time_idx(lm_delta_time_idx),
        .lm_delta_time_max(lm_delta_time_max), .lm_delta_time_min(lm_delta_time_min)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // tx in one cycle, rx in the next, then the WRITE cycle; FSM ends back in ARMED.
    task automatic send_pair(input logic [15:0] s, input logic [15:0] r);
        tx_sop = 1'b1; timer = s; tick();
        tx_sop = 1'b0; rx_sop = 1'b1; timer = r; tick();
        rx_sop = 1'b0; timer = 16'h0; tick();
    endtask

    // Pop and advance to the cycle where the ready pulse is visible.
    task automatic pop_req();
        lm_pop = 1'b1; tick();
        lm_pop = 1'b0; tick();
    endtask

    task automatic do_clear();
        lm_clear = 1'b1; tick();
        lm_clear = 1'b0; tick();
    endtask

    initial begin
        rst_n = 1'b0; lm_go = 1'b0; lm_clear = 1'b0; lm_pop = 1'b0;
        lm_lat_pkt_cnt = 32'd0; timer = 16'h0; tx_sop = 1'b0; rx_sop = 1'b0;
        tick(); tick();
        rst_n = 1'b1; tick();

        // Reset state
        check("rst_datav", 32'(lm_datav), 32'd0);
        check("rst_full", 32'(lm_full), 32'd0);
        check("rst_min", 32'(lm_delta_time_min), 32'hFFFF);
        check("rst_max", 32'(lm_delta_time_max), 32'd0);
        check("rst_accu", lm_delta_time_accu, 32'd0);
        check("rst_idx", lm_delta_time_idx, 32'd0);
        check("rst_rdy", 32'(lm_time_rdy), 32'd0);
        check("rst_snd", 32'(lm_snd_time), 32'd0);

        // Basic pair 100 -> 130
        lm_go = 1'b1; tick();
        send_pair(16'd100, 16'd130);
        check("basic_datav", 32'(lm_datav), 32'd1);
        check("basic_accu", lm_delta_time_accu, 32'd30);
        check("basic_idx", lm_delta_time_idx, 32'd1);
        check("basic_max", 32'(lm_delta_time_max), 32'd30);
        check("basic_min", 32'(lm_delta_time_min), 32'd30);
        lm_pop = 1'b1; tick();
        lm_pop = 1'b0;
        check("basic_datav_p1", 32'(lm_datav), 32'd0);
        check("basic_rdy_p1", 32'(lm_time_rdy), 32'd0);
        tick();
        check("basic_rdy_p2", 32'(lm_time_rdy), 32'd1);
        check("basic_snd", 32'(lm_snd_time), 32'd100);
        check("basic_rcv", 32'(lm_rcv_time), 32'd130);
        tick();
        check("basic_rdy_p3", 32'(lm_time_rdy), 32'd0);
        check("basic_snd_hold", 32'(lm_snd_time), 32'd100);

        // Timer wrap: 0xFFF0 -> 0x0010, delta 32
        send_pair(16'hFFF0, 16'h0010);
        check("wrap_accu", lm_delta_time_accu, 32'd62);
        check("wrap_idx", lm_delta_time_idx, 32'd2);
        check("wrap_max", 32'(lm_delta_time_max), 32'd32);
        check("wrap_min", 32'(lm_delta_time_min), 32'd30);
        pop_req();
        check("wrap_rdy", 32'(lm_time_rdy), 32'd1);
        check("wrap_snd", 32'(lm_snd_time), 32'hFFF0);
        check("wrap_rcv", 32'(lm_rcv_time), 32'h0010);
        tick();

        // Clear, then fill past capacity
        do_clear();
        check("clr_datav", 32'(lm_datav), 32'd0);
        check("clr_idx", lm_delta_time_idx, 32'd0);
        check("clr_min", 32'(lm_delta_time_min), 32'hFFFF);
        check("clr_max", 32'(lm_delta_time_max), 32'd0);
        for (int i = 0; i < 4098; i++)
            send_pair(16'(i), 16'(i + 5));
        check("fill_full", 32'(lm_full), 32'd1);
        check("fill_datav", 32'(lm_datav), 32'd4096);
        check("fill_idx", lm_delta_time_idx, 32'd4098);
        check("fill_accu", lm_delta_time_accu, 32'd20490);
        check("fill_min", 32'(lm_delta_time_min), 32'd5);
        lm_pop = 1'b1; tick();
        lm_pop = 1'b0;
        check("fill_datav_pop", 32'(lm_datav), 32'd4095);
        check("fill_full_pop", 32'(lm_full), 32'd0);
        tick();
        check("fill_rdy", 32'(lm_time_rdy), 32'd1);
        check("fill_snd", 32'(lm_snd_time), 32'd0);
        check("fill_rcv", 32'(lm_rcv_time), 32'd5);
        tick();

        // Packet count limit of 3 with 5 pairs offered
        lm_lat_pkt_cnt = 32'd3;
        do_clear();
        send_pair(16'd10, 16'd13);
        send_pair(16'd20, 16'd27);
        send_pair(16'd30, 16'd41);
        send_pair(16'd40, 16'd50);
        send_pair(16'd50, 16'd70);
        check("cnt_datav", 32'(lm_datav), 32'd3);
        check("cnt_idx", lm_delta_time_idx, 32'd3);
        check("cnt_accu", lm_delta_time_accu, 32'd21);
        check("cnt_max", 32'(lm_delta_time_max), 32'd11);
        check("cnt_min", 32'(lm_delta_time_min), 32'd3);
        lm_go = 1'b0; tick();
        lm_go = 1'b1; tick();
        send_pair(16'd60, 16'd62);
        check("rearm_datav", 32'(lm_datav), 32'd4);
        check("rearm_min", 32'(lm_delta_time_min), 32'd2);
        // Second pop one cycle after the first is in flight and must be ignored
        lm_pop = 1'b1; tick();
        tick();
        lm_pop = 1'b0;
        check("inflight_rdy", 32'(lm_time_rdy), 32'd1);
        check("inflight_snd", 32'(lm_snd_time), 32'd10);
        check("inflight_rcv", 32'(lm_rcv_time), 32'd13);
        check("inflight_datav", 32'(lm_datav), 32'd3);
        tick();
        pop_req(); tick();
        pop_req();
        check("cnt_pop3_snd", 32'(lm_snd_time), 32'd30);
        tick();
        pop_req();
        check("cnt_pop4_snd", 32'(lm_snd_time), 32'd60);
        check("cnt_pop4_rcv", 32'(lm_rcv_time), 32'd62);
        tick();
        pop_req();
        check("empty_rdy", 32'(lm_time_rdy), 32'd1);
        check("empty_snd", 32'(lm_snd_time), 32'd0);
        check("empty_rcv", 32'(lm_rcv_time), 32'd0);
        tick();

        // Simultaneous tx+rx in WAIT_RX, then clear during an in-flight pop
        lm_lat_pkt_cnt = 32'd0;
        do_clear();
        tx_sop = 1'b1; timer = 16'd200; tick();
        rx_sop = 1'b1; timer = 16'd250; tick();
        tx_sop = 1'b0; rx_sop = 1'b0; tick();
        check("simul_datav", 32'(lm_datav), 32'd1);
        check("simul_accu", lm_delta_time_accu, 32'd50);
        rx_sop = 1'b1; timer = 16'd400; tick();
        rx_sop = 1'b0; tick(); tick();
        check("lone_rx_datav", 32'(lm_datav), 32'd1);
        send_pair(16'd300, 16'd301);
        check("simul_datav2", 32'(lm_datav), 32'd2);
        pop_req();
        check("simul_snd", 32'(lm_snd_time), 32'd200);
        check("simul_rcv", 32'(lm_rcv_time), 32'd250);
        tick();
        lm_pop = 1'b1; tick();
        lm_pop = 1'b0; lm_clear = 1'b1; tick();
        lm_clear = 1'b0;
        check("clrpop_datav", 32'(lm_datav), 32'd0);
        check("clrpop_accu", lm_delta_time_accu, 32'd0);
        check("clrpop_idx", lm_delta_time_idx, 32'd0);
        check("clrpop_min", 32'(lm_delta_time_min), 32'hFFFF);
        check("clrpop_rdy", 32'(lm_time_rdy), 32'd1);
        check("clrpop_snd", 32'(lm_snd_time), 32'd0);
        check("clrpop_rcv", 32'(lm_rcv_time), 32'd0);
        tick();
        check("clrpop_rdy_end", 32'(lm_time_rdy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
